// File: rtl/tpu_tile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tpu_tile_sequencer_if
// Brief    : Control/bus bundle between the tile sequencer and the TPU
//            datapath (config, Weight FIFO, UB read port, Results SRAM port).
// Revision : 1.0 - initial release
// ============================================================================
interface tpu_tile_sequencer_if #(
  parameter int ADDRESSSIZE = 10,
  parameter int ROW_BW      = 10,
  parameter int TILE_BW     = 4
) ();
  logic                   start;
  logic [ADDRESSSIZE-1:0] cfg_ub_base;
  logic [ADDRESSSIZE-1:0] cfg_res_base;
  logic [ROW_BW-1:0]      cfg_num_rows;
  logic [TILE_BW-1:0]     cfg_num_tiles;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic                   we_rl;
  logic                   ub_rd_en;
  logic [ADDRESSSIZE-1:0] ub_addr;
  logic                   res_we;
  logic [ADDRESSSIZE-1:0] res_addr;
  logic                   busy;
  logic                   done;
  logic [TILE_BW-1:0]     tile_idx;

  // Sequencer side: consumes config and FIFO status, drives all strobes.
  modport master (
    input  start, cfg_ub_base, cfg_res_base, cfg_num_rows, cfg_num_tiles,
           fifo_empty,
    output fifo_rd_en, we_rl, ub_rd_en, ub_addr, res_we, res_addr,
           busy, done, tile_idx
  );

  // Datapath/host side.
  modport slave (
    output start, cfg_ub_base, cfg_res_base, cfg_num_rows, cfg_num_tiles,
           fifo_empty,
    input  fifo_rd_en, we_rl, ub_rd_en, ub_addr, res_we, res_addr,
           busy, done, tile_idx
  );
endinterface
`default_nettype wire

// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_tile_sequencer
// Brief    : Tile sequencer for the TPU datapath. Per tile: pop one weight
//            set, pulse weight reload, stream activation rows from the UB and
//            write each result row to the Results SRAM after the fixed
//            UB + array latency.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_tile_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 8,
  parameter int UB_RD_LAT   = 1,
  parameter int ARRAY_LAT   = 2 * MATRIX_SIZE,
  parameter int ROW_BW      = 10,
  parameter int TILE_BW     = 4
) (
  input logic                 clk,
  input logic                 rstn,
  tpu_tile_sequencer_if.master bus
);

  // Cycles from an issued UB read to its result row being written.
  localparam int DEPTH = UB_RD_LAT + ARRAY_LAT;

  localparam logic [ADDRESSSIZE-1:0] ADDR_ONE = ADDRESSSIZE'(1);
  localparam logic [ROW_BW-1:0]      ROW_ONE  = ROW_BW'(1);
  localparam logic [TILE_BW-1:0]     TILE_ONE = TILE_BW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_WLOAD  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 state;
  logic [ADDRESSSIZE-1:0] ub_base;
  logic [ROW_BW-1:0]      rows_cfg;
  logic [TILE_BW-1:0]     tiles_cfg;
  logic [ROW_BW-1:0]      row_cnt;
  logic [DEPTH-1:0]       valid_pipe;

  logic [DEPTH-1:0]       pipe_next;
  logic [TILE_BW-1:0]     tile_next;
  logic                   last_row;
  logic                   cfg_zero;

  // Each registered UB read strobe enters the pipe; the top bit is the write.
  assign pipe_next  = DEPTH'({valid_pipe, bus.ub_rd_en});
  assign bus.res_we = valid_pipe[DEPTH-1];
  assign tile_next  = bus.tile_idx + TILE_ONE;
  assign last_row   = (row_cnt + ROW_ONE) == rows_cfg;
  assign cfg_zero   = (bus.cfg_num_rows == '0) || (bus.cfg_num_tiles == '0);

  // Sequencer FSM with registered strobes, result pipe and result address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      ub_base        <= '0;
      rows_cfg       <= '0;
      tiles_cfg      <= '0;
      row_cnt        <= '0;
      valid_pipe     <= '0;
      bus.fifo_rd_en <= 1'b0;
      bus.we_rl      <= 1'b0;
      bus.ub_rd_en   <= 1'b0;
      bus.ub_addr    <= '0;
      bus.res_addr   <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.tile_idx   <= '0;
    end else begin
      bus.fifo_rd_en <= 1'b0;
      bus.we_rl      <= 1'b0;
      bus.ub_rd_en   <= 1'b0;
      bus.done       <= 1'b0;
      valid_pipe     <= pipe_next;
      // Result address runs contiguously across tiles.
      if (bus.res_we) begin
        bus.res_addr <= bus.res_addr + ADDR_ONE;
      end

      unique case (state)
        S_IDLE: begin
          // busy falls one cycle after done, so a start coincident with
          // the done pulse is still ignored.
          bus.busy <= 1'b0;
          if (bus.start && !bus.busy) begin
            ub_base      <= bus.cfg_ub_base;
            rows_cfg     <= bus.cfg_num_rows;
            tiles_cfg    <= bus.cfg_num_tiles;
            bus.ub_addr  <= bus.cfg_ub_base;
            bus.res_addr <= bus.cfg_res_base;
            bus.tile_idx <= '0;
            bus.busy     <= 1'b1;
            // An empty run passes through DRAIN (pipe already empty) so its
            // done pulse has the same two-cycle start-to-done latency as
            // the end of a real run.
            state        <= cfg_zero ? S_DRAIN : S_LOAD_W;
          end
        end

        S_LOAD_W: begin
          if (!bus.fifo_empty) begin
            bus.fifo_rd_en <= 1'b1;
            state          <= S_WLOAD;
          end
        end

        S_WLOAD: begin
          bus.we_rl   <= 1'b1;
          row_cnt     <= '0;
          bus.ub_addr <= ub_base;
          state       <= S_STREAM;
        end

        S_STREAM: begin
          bus.ub_rd_en <= 1'b1;
          row_cnt      <= row_cnt + ROW_ONE;
          // The first read uses the base loaded in WLOAD.
          if (row_cnt != '0) begin
            bus.ub_addr <= bus.ub_addr + ADDR_ONE;
          end
          if (last_row) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // Leave once the pipe will be empty after this edge.
          if (pipe_next == '0) begin
            if ((rows_cfg != '0) && (tile_next < tiles_cfg)) begin
              bus.tile_idx <= tile_next;
              state        <= S_LOAD_W;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          bus.done <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_tile_sequencer
// Brief    : Self-checking bench for tpu_tile_sequencer. A timeline model
//            computes every strobe per cycle from the run configuration and
//            the FIFO-empty pattern; one process compares the DUT each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_tile_sequencer;

  localparam int AW   = 10;
  localparam int RW   = 10;
  localparam int TW   = 4;
  localparam int D    = 17;   // UB_RD_LAT 1 + ARRAY_LAT 16
  localparam int MAXR = 1024;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  tpu_tile_sequencer_if #(.ADDRESSSIZE(AW), .ROW_BW(RW), .TILE_BW(TW)) bus ();

  tpu_tile_sequencer #(
    .ADDRESSSIZE(AW), .MATRIX_SIZE(8), .UB_RD_LAT(1), .ARRAY_LAT(16),
    .ROW_BW(RW), .TILE_BW(TW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int run_start = 0;
  bit run_valid = 1'b0;
  bit chk_en    = 1'b0;

  // FIFO empty pattern, indexed by cycle relative to the run's start edge.
  bit emp [MAXR];

  // Expected per-cycle outputs of the current run.
  bit            e_fifo [MAXR];
  bit            e_wrl  [MAXR];
  bit            e_rd   [MAXR];
  bit            e_wr   [MAXR];
  bit            e_done [MAXR];
  bit            e_busy [MAXR];
  logic [AW-1:0] e_ub   [MAXR];
  logic [AW-1:0] e_res  [MAXR];
  logic [TW-1:0] e_tile [MAXR];
  int            m_fifo [$];
  int            m_first_wr;
  int            m_done;

  task automatic chk(input string nm, input int at, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at=%0d actual=0x%0h required=0x%0h", nm, at, act, req);
    end
  endtask

  // Timeline model: each tile pops at the first non-empty cycle once ready,
  // reload follows, N reads follow, writes trail reads by D, and the next
  // tile (or done) is ready two cycles after the last write.
  function automatic void build_model(input logic [AW-1:0] ub, input logic [AW-1:0] res,
                                      input int rows, input int tiles);
    int c;
    int ready;
    int last;
    logic [AW-1:0] ra;
    for (int i = 0; i < MAXR; i++) begin
      e_fifo[i] = 1'b0; e_wrl[i] = 1'b0; e_rd[i] = 1'b0; e_wr[i] = 1'b0;
      e_done[i] = 1'b0; e_busy[i] = 1'b0;
      e_ub[i] = '0; e_res[i] = '0; e_tile[i] = '0;
    end
    m_fifo.delete();
    m_first_wr = -1;
    ra    = res;
    ready = 1;
    last  = 0;
    if (rows == 0 || tiles == 0) begin
      m_done = 2;
    end else begin
      for (int t = 0; t < tiles; t++) begin
        c = ready;
        while (emp[c]) c++;
        e_fifo[c] = 1'b1;
        m_fifo.push_back(c);
        e_wrl[c+1] = 1'b1;
        for (int r = 0; r < rows; r++) begin
          e_rd[c+2+r]    = 1'b1;
          e_ub[c+2+r]    = ub + AW'(r);
          e_tile[c+2+r]  = TW'(t);
          e_wr[c+2+D+r]  = 1'b1;
          e_res[c+2+D+r] = ra;
          ra = ra + AW'(1);
        end
        if (m_first_wr < 0) m_first_wr = c + 2 + D;
        last  = c + 1 + D + rows;
        ready = last + 2;
      end
      m_done = last + 2;
    end
    e_done[m_done] = 1'b1;
    for (int i = 0; i <= m_done; i++) e_busy[i] = 1'b1;
  endfunction

  // Single compare process: every cycle, 1 time unit after the rising edge.
  initial begin
    int rel;
    bit v;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_en) begin
        rel = cyc - run_start;
        v   = run_valid && rel >= 0 && rel < MAXR;
        if (!v) rel = 0;
        chk("fifo_rd_en", rel, 32'(bus.fifo_rd_en), v ? 32'(e_fifo[rel]) : 32'd0);
        chk("we_rl",      rel, 32'(bus.we_rl),      v ? 32'(e_wrl[rel])  : 32'd0);
        chk("ub_rd_en",   rel, 32'(bus.ub_rd_en),   v ? 32'(e_rd[rel])   : 32'd0);
        chk("res_we",     rel, 32'(bus.res_we),     v ? 32'(e_wr[rel])   : 32'd0);
        chk("done",       rel, 32'(bus.done),       v ? 32'(e_done[rel]) : 32'd0);
        chk("busy",       rel, 32'(bus.busy),       v ? 32'(e_busy[rel]) : 32'd0);
        if (v && e_rd[rel]) begin
          chk("ub_addr",  rel, 32'(bus.ub_addr),  32'(e_ub[rel]));
          chk("tile_idx", rel, 32'(bus.tile_idx), 32'(e_tile[rel]));
        end
        if (v && e_wr[rel]) begin
          chk("res_addr", rel, 32'(bus.res_addr), 32'(e_res[rel]));
        end
      end
    end
  end

  // Advance to the falling edge and drive fifo_empty for the next edge.
  task automatic tick();
    int rn;
    @(negedge clk);
    rn = cyc + 1 - run_start;
    if (run_valid && rn >= 0 && rn < MAXR) bus.fifo_empty = emp[rn];
    else bus.fifo_empty = 1'($urandom_range(0, 1));
  endtask

  task automatic scramble_cfg();
    bus.cfg_ub_base   = AW'($urandom);
    bus.cfg_res_base  = AW'($urandom);
    bus.cfg_num_rows  = RW'($urandom);
    bus.cfg_num_tiles = TW'($urandom);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_fifo_rd_en"}, 0, 32'(bus.fifo_rd_en), 32'd0);
    chk({tag, "_we_rl"},      0, 32'(bus.we_rl),      32'd0);
    chk({tag, "_ub_rd_en"},   0, 32'(bus.ub_rd_en),   32'd0);
    chk({tag, "_ub_addr"},    0, 32'(bus.ub_addr),    32'd0);
    chk({tag, "_res_we"},     0, 32'(bus.res_we),     32'd0);
    chk({tag, "_res_addr"},   0, 32'(bus.res_addr),   32'd0);
    chk({tag, "_busy"},       0, 32'(bus.busy),       32'd0);
    chk({tag, "_done"},       0, 32'(bus.done),       32'd0);
    chk({tag, "_tile_idx"},   0, 32'(bus.tile_idx),   32'd0);
  endtask

  task automatic clear_emp();
    for (int i = 0; i < MAXR; i++) emp[i] = 1'b0;
  endtask

  // One run: again_rel>0 re-pulses start at that cycle (-1 = random while
  // busy); rst_rel>0 drops rstn at that cycle and ends the run.
  task automatic do_run(input logic [AW-1:0] ub, input logic [AW-1:0] res,
                        input logic [RW-1:0] rows, input logic [TW-1:0] tiles,
                        input int again_rel, input int rst_rel, input bit scramble);
    int again;
    run_valid = 1'b0;
    build_model(ub, res, int'(rows), int'(tiles));
    again = (again_rel < 0) ? int'($urandom_range(1, m_done)) : again_rel;
    tick();
    bus.start         = 1'b1;
    bus.cfg_ub_base   = ub;
    bus.cfg_res_base  = res;
    bus.cfg_num_rows  = rows;
    bus.cfg_num_tiles = tiles;
    run_start         = cyc + 1;
    run_valid         = 1'b1;
    bus.fifo_empty    = emp[0];
    for (int k = 1; k <= m_done + 3; k++) begin
      tick();
      bus.start = (k == again);
      if (scramble) scramble_cfg();
      if (k == rst_rel) begin
        bus.start = 1'b0;
        rstn      = 1'b0;
        run_valid = 1'b0;
        #1;
        all_zero("midrst");
        tick();
        tick();
        rstn = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.cfg_ub_base = '0; bus.cfg_res_base = '0;
    bus.cfg_num_rows = '0; bus.cfg_num_tiles = '0;
    clear_emp();
    repeat (3) @(negedge clk);
    #1;
    all_zero("reset");
    rstn   = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // Base run.
    do_run(10'h010, 10'h100, 10'd4, 4'd2, 0, 0, 1'b0);
    chk("pin_base_fifo0", 0, 32'(m_fifo[0]), 32'd1);
    chk("pin_base_fifo1", 0, 32'(m_fifo[1]), 32'd25);
    chk("pin_base_wr0",   0, 32'(m_first_wr), 32'd20);
    chk("pin_base_done",  0, 32'(m_done), 32'd49);
    chk("pin_base_res44", 0, 32'(e_res[44]), 32'h104);
    chk("pin_base_ub30",  0, 32'(e_ub[30]), 32'h013);

    // FIFO stall for cycles 0-9.
    for (int i = 0; i <= 9; i++) emp[i] = 1'b1;
    do_run(10'h010, 10'h100, 10'd4, 4'd2, 0, 0, 1'b0);
    chk("pin_stall_fifo0", 0, 32'(m_fifo[0]), 32'd10);
    chk("pin_stall_wr0",   0, 32'(m_first_wr), 32'd29);
    clear_emp();

    // Start while busy at cycle 10, with config inputs changing mid-run.
    do_run(10'h010, 10'h100, 10'd4, 4'd2, 10, 0, 1'b1);

    // Zero configurations.
    do_run(10'h020, 10'h040, 10'd0, 4'd3, 0, 0, 1'b0);
    chk("pin_zero_rows_done", 0, 32'(m_done), 32'd2);
    do_run(10'h020, 10'h040, 10'd5, 4'd0, 0, 0, 1'b0);
    chk("pin_zero_tiles_done", 0, 32'(m_done), 32'd2);

    // Address wrap.
    do_run(10'h3FE, 10'h3FF, 10'd3, 4'd1, 0, 0, 1'b0);
    chk("pin_wrap_ub",  0, 32'(e_ub[5]), 32'h000);
    chk("pin_wrap_res", 0, 32'(e_res[m_first_wr + 2]), 32'h001);

    // Reset during STREAM of tile 0, idle a while, then the base run again.
    do_run(10'h010, 10'h100, 10'd4, 4'd2, 0, 5, 1'b0);
    repeat (25) tick();
    do_run(10'h010, 10'h100, 10'd4, 4'd2, 0, 0, 1'b0);

    // Randomised runs with random FIFO stalls and start re-pulses.
    for (int n = 0; n < 25; n++) begin
      clear_emp();
      for (int i = 0; i < 300; i++) emp[i] = ($urandom_range(0, 3) == 0);
      do_run(AW'($urandom), AW'($urandom),
             RW'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12)),
             TW'($urandom_range(0, 4)), -1, 0, 1'b1);
    end
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
